// File: rtl/vending_machine_pn.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vending_machine_pn : parametrised vending controller, half-unit credit,
// sell/ack handshake, encoded change and cancel/timeout refund.  Rev 1.0
// ---------------------------------------------------------------------------
module vending_machine_pn #(
  parameter int PRICE    = 3,
  parameter int CREDIT_W = 4,
  parameter int TIMEOUT  = 16,
  parameter int COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                vend_ack,
  output logic                sell,
  output logic [CREDIT_W-1:0] change,
  output logic                change_vld,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [COUNT_W-1:0]  sold_cnt
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CREDIT_W:0] PRICE_X  = (CREDIT_W + 1)'(PRICE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                change_vld_q, change_vld_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sell_q, sell_d;
  logic [COUNT_W-1:0]  sold_cnt_q, sold_cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      change_q      <= '0;
      change_vld_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      sell_q        <= 1'b0;
      sold_cnt_q    <= '0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      change_q      <= change_d;
      change_vld_q  <= change_vld_d;
      coin_reject_q <= coin_reject_d;
      sell_q        <= sell_d;
      sold_cnt_q    <= sold_cnt_d;
      tmo_q         <= tmo_d;
    end
  end

  always_comb begin
    coin_val = '0;
    case (coin)
      2'b01:   coin_val = (CREDIT_W + 1)'(1);
      2'b10:   coin_val = (CREDIT_W + 1)'(2);
      2'b11:   coin_val = (CREDIT_W + 1)'(4);
      default: coin_val = '0;
    endcase
    // One spare bit keeps credit+coin from wrapping before the price compare.
    sum = {1'b0, credit_q} + coin_val;
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    change_d      = '0;
    change_vld_d  = 1'b0;
    coin_reject_d = 1'b0;
    sold_cnt_d    = sold_cnt_q;
    tmo_d         = tmo_q;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (cancel) begin
          coin_reject_d = (coin != 2'b00);
          if (state_q == ST_COLLECT) begin
            change_d     = credit_q;
            change_vld_d = (credit_q != '0);
            credit_d     = '0;
            tmo_d        = '0;
            state_d      = ST_IDLE;
          end
        end else if (coin != 2'b00) begin
          tmo_d = '0;
          if (sum >= PRICE_X) begin
            state_d      = ST_VEND;
            credit_d     = '0;
            sold_cnt_d   = sold_cnt_q + COUNT_W'(1);
            change_d     = CREDIT_W'(sum - PRICE_X);
            change_vld_d = (sum != PRICE_X);
          end else begin
            state_d  = ST_COLLECT;
            credit_d = sum[CREDIT_W-1:0];
          end
        end else if (state_q == ST_COLLECT && TIMEOUT != 0) begin
          // Idle cycle: the TIMEOUT-th consecutive one refunds like a cancel.
          if (tmo_q == TMO_LAST) begin
            change_d     = credit_q;
            change_vld_d = (credit_q != '0);
            credit_d     = '0;
            tmo_d        = '0;
            state_d      = ST_IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      ST_VEND: begin
        coin_reject_d = (coin != 2'b00);
        if (vend_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        tmo_d    = '0;
      end
    endcase

    sell_d = (state_d == ST_VEND);
  end

  assign sell        = sell_q;
  assign change      = change_q;
  assign change_vld  = change_vld_q;
  assign coin_reject = coin_reject_q;
  assign credit      = credit_q;
  assign sold_cnt    = sold_cnt_q;

endmodule
`default_nettype wire
